// File: rtl/nh_lcd_frame_sequencer.sv
// nh_lcd power-up and frame sequencer: init, window setup, RAMWR, pixel streaming.
// Optional NH_LCD_SEQ_TE_SYNC_EN adds a tearing-effect wait before streaming.
module nh_lcd_frame_sequencer #(
    parameter int unsigned RESET_CYCLES      = 16,
    parameter int unsigned RESET_WAIT_CYCLES = 64,
    parameter int unsigned SLEEP_WAIT_CYCLES = 128,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic        i_start,
    input  logic [15:0] i_x_start,
    input  logic [15:0] i_x_end,
    input  logic [15:0] i_y_start,
    input  logic [15:0] i_y_end,
    input  logic        i_pixel_stb,
    input  logic        i_cmd_finished,
`ifdef NH_LCD_SEQ_TE_SYNC_EN
    input  logic        i_tearing_effect,
`endif
    output logic        o_cmd_mode,
    output logic        o_cmd_parameter,
    output logic        o_cmd_write_stb,
    output logic [7:0]  o_cmd_data,
    output logic        o_reset_display,
    output logic        o_chip_select,
    output logic [31:0] o_num_pixels,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_error
);

    typedef enum logic [3:0] {
        S_PWR_RST,
        S_PWR_WAIT,
        S_SLPOUT,
        S_SLP_WAIT,
        S_DISPON,
        S_READY,
        S_CASET,
        S_PASET,
        S_RAMWR,
        S_STREAM
`ifdef NH_LCD_SEQ_TE_SYNC_EN
        , S_TE_WAIT
`endif
    } state_e;

    localparam logic [CNT_WIDTH-1:0] RST_LIM =
        (RESET_CYCLES == 0) ? '0 : CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RWAIT_LIM =
        (RESET_WAIT_CYCLES == 0) ? '0 : CNT_WIDTH'(RESET_WAIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SWAIT_LIM =
        (SLEEP_WAIT_CYCLES == 0) ? '0 : CNT_WIDTH'(SLEEP_WAIT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 pend_q, pend_d;
    logic                 hdr_q, hdr_d;
    logic [1:0]           pidx_q, pidx_d;
    logic                 stb_q, stb_d;
    logic [7:0]           data_q, data_d;
    logic                 param_q, param_d;
    logic [15:0]          xs_q, xs_d, xe_q, xe_d;
    logic [15:0]          ys_q, ys_d, ye_q, ye_d;
    logic [31:0]          num_q, num_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 mode_q, mode_d;
    logic                 rstd_q, rstd_d;
    logic                 cs_q, cs_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic                 byte_ack;
    logic                 multi;
    logic [15:0]          coord;
    logic [7:0]           cmd_byte, cur_byte;
    logic [16:0]          w, h;
    logic [31:0]          prod;
    logic                 win_bad;
    state_e               cmd_next;

`ifdef NH_LCD_SEQ_TE_SYNC_EN
    logic te_s1_q, te_s2_q, te_prev_q, te_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            te_s1_q   <= 1'b0;
            te_s2_q   <= 1'b0;
            te_prev_q <= 1'b0;
        end else begin
            te_s1_q   <= i_tearing_effect;
            te_s2_q   <= te_s1_q;
            te_prev_q <= te_s2_q;
        end
    end

    assign te_rise = te_s2_q & ~te_prev_q;
`endif

    // finished is only honoured once the strobe cycle has passed
    assign byte_ack = pend_q && !stb_q && i_cmd_finished;
    assign multi    = (state_q == S_CASET) || (state_q == S_PASET);
    assign cnt_inc  = cnt_q + CNT_WIDTH'(1);
    assign w        = {1'b0, i_x_end} - {1'b0, i_x_start} + 17'd1;
    assign h        = {1'b0, i_y_end} - {1'b0, i_y_start} + 17'd1;
    assign prod     = 32'(w) * 32'(h);
    assign win_bad  = (i_x_end < i_x_start) || (i_y_end < i_y_start);

    always_comb begin
        coord    = 16'h0;
        cmd_byte = 8'h2C;
        cmd_next = S_READY;
        case (state_q)
            S_SLPOUT: begin
                cmd_byte = 8'h11;
                cmd_next = S_SLP_WAIT;
            end
            S_DISPON: begin
                cmd_byte = 8'h29;
                cmd_next = S_READY;
            end
            S_CASET: begin
                cmd_byte = 8'h2A;
                cmd_next = S_PASET;
                coord    = pidx_q[1] ? xe_q : xs_q;
            end
            S_PASET: begin
                cmd_byte = 8'h2B;
                cmd_next = S_RAMWR;
                coord    = pidx_q[1] ? ye_q : ys_q;
            end
            S_RAMWR: begin
                cmd_byte = 8'h2C;
`ifdef NH_LCD_SEQ_TE_SYNC_EN
                cmd_next = S_TE_WAIT;
`else
                cmd_next = S_STREAM;
`endif
            end
            default: ;
        endcase
        cur_byte = hdr_q ? (pidx_q[0] ? coord[7:0] : coord[15:8]) : cmd_byte;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hdr_d   = hdr_q;
        pidx_d  = pidx_q;
        stb_d   = 1'b0;
        data_d  = data_q;
        param_d = param_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        ys_d    = ys_q;
        ye_d    = ye_q;
        num_d   = num_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (!i_enable) begin
            cnt_d = '0;
            if (state_q inside {S_PWR_RST, S_PWR_WAIT, S_SLPOUT,
                                S_SLP_WAIT, S_DISPON})
                state_d = S_PWR_RST;
            else
                state_d = S_READY;
        end else begin
            case (state_q)
                S_PWR_RST: begin
                    if (cnt_q >= RST_LIM) state_d = S_PWR_WAIT;
                    else cnt_d = cnt_inc;
                end
                S_PWR_WAIT: begin
                    if (cnt_q >= RWAIT_LIM) state_d = S_SLPOUT;
                    else cnt_d = cnt_inc;
                end
                S_SLP_WAIT: begin
                    if (cnt_q >= SWAIT_LIM) state_d = S_DISPON;
                    else cnt_d = cnt_inc;
                end
                S_SLPOUT, S_DISPON, S_CASET, S_PASET, S_RAMWR: begin
                    if (!pend_q) begin
                        stb_d   = 1'b1;
                        pend_d  = 1'b1;
                        data_d  = cur_byte;
                        param_d = hdr_q;
                    end else if (byte_ack) begin
                        pend_d = 1'b0;
                        if (multi && !hdr_q) hdr_d = 1'b1;
                        else if (multi && pidx_q != 2'd3) pidx_d = pidx_q + 2'd1;
                        else state_d = cmd_next;
                    end
                end
                S_READY: begin
                    if (i_start) begin
                        if (win_bad) begin
                            err_d = 1'b1;
                        end else begin
                            err_d   = 1'b0;
                            xs_d    = i_x_start;
                            xe_d    = i_x_end;
                            ys_d    = i_y_start;
                            ye_d    = i_y_end;
                            num_d   = prod;
                            state_d = S_CASET;
                        end
                    end
                end
`ifdef NH_LCD_SEQ_TE_SYNC_EN
                S_TE_WAIT: begin
                    if (te_rise) state_d = S_STREAM;
                end
`endif
                S_STREAM: begin
                    if (i_pixel_stb) begin
                        if (32'(cnt_inc) == num_q) begin
                            done_d  = 1'b1;
                            state_d = S_READY;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: state_d = S_PWR_RST;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            hdr_d  = 1'b0;
            pidx_d = 2'd0;
        end

        mode_d  = (state_d != S_STREAM);
        rstd_d  = (state_d == S_PWR_RST);
        cs_d    = (state_d != S_PWR_RST);
        ready_d = (state_d == S_READY);
        busy_d  = (state_d != S_READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWR_RST;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            hdr_q   <= 1'b0;
            pidx_q  <= 2'd0;
            stb_q   <= 1'b0;
            data_q  <= 8'h00;
            param_q <= 1'b0;
            xs_q    <= 16'h0;
            xe_q    <= 16'h0;
            ys_q    <= 16'h0;
            ye_q    <= 16'h0;
            num_q   <= 32'h0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b1;
            rstd_q  <= 1'b1;
            cs_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hdr_q   <= hdr_d;
            pidx_q  <= pidx_d;
            stb_q   <= stb_d;
            data_q  <= data_d;
            param_q <= param_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            ys_q    <= ys_d;
            ye_q    <= ye_d;
            num_q   <= num_d;
            err_q   <= err_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            rstd_q  <= rstd_d;
            cs_q    <= cs_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign o_cmd_mode      = mode_q;
    assign o_cmd_parameter = param_q;
    assign o_cmd_write_stb = stb_q;
    assign o_cmd_data      = data_q;
    assign o_reset_display = rstd_q;
    assign o_chip_select   = cs_q;
    assign o_num_pixels    = num_q;
    assign o_ready         = ready_q;
    assign o_busy          = busy_q;
    assign o_frame_done    = done_q;
    assign o_error         = err_q;

endmodule

// File: tb/tb_nh_lcd_frame_sequencer.sv
// Directed bench for nh_lcd_frame_sequencer with a 3-cycle command-engine responder.
module tb_nh_lcd_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_x_start = 16'd0;
    logic [15:0] i_x_end = 16'd0;
    logic [15:0] i_y_start = 16'd0;
    logic [15:0] i_y_end = 16'd0;
    logic        i_pixel_stb = 1'b0;
    logic        i_cmd_finished = 1'b0;
    logic        o_cmd_mode, o_cmd_parameter, o_cmd_write_stb;
    logic [7:0]  o_cmd_data;
    logic        o_reset_display, o_chip_select;
    logic [31:0] o_num_pixels;
    logic        o_ready, o_busy, o_frame_done, o_error;
`ifdef NH_LCD_SEQ_TE_SYNC_EN
    logic        te = 1'b0;
    always #137 te = ~te;
`endif

    nh_lcd_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_start(i_start),
        .i_x_start(i_x_start), .i_x_end(i_x_end),
        .i_y_start(i_y_start), .i_y_end(i_y_end),
        .i_pixel_stb(i_pixel_stb), .i_cmd_finished(i_cmd_finished),
`ifdef NH_LCD_SEQ_TE_SYNC_EN
        .i_tearing_effect(te),
`endif
        .o_cmd_mode(o_cmd_mode), .o_cmd_parameter(o_cmd_parameter),
        .o_cmd_write_stb(o_cmd_write_stb), .o_cmd_data(o_cmd_data),
        .o_reset_display(o_reset_display), .o_chip_select(o_chip_select),
        .o_num_pixels(o_num_pixels), .o_ready(o_ready), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;
    int cyc = 0;
    int cd = 0;
    int rd_cnt = 0;
    logic [8:0] log_q[$];
    int stb_t[$];

    // command-engine model: finished pulses 3 cycles after each strobe
    always @(negedge clk) begin
        cyc++;
        i_cmd_finished = 1'b0;
        if (!rst_n) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) i_cmd_finished = 1'b1;
            end
            if (o_cmd_write_stb) begin
                cd = 3;
                log_q.push_back({o_cmd_parameter, o_cmd_data});
                stb_t.push_back(cyc);
            end
            if (o_reset_display) rd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (o_ready !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("ready_timeout", 32'(k < budget), 32'd1);
    endtask

    task automatic wait_mode0(input int budget);
        int k = 0;
        while (o_cmd_mode !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("mode0_timeout", 32'(k < budget), 32'd1);
    endtask

    task automatic wait_stb(input int n, input int budget);
        int k = 0;
        int seen = 0;
        while (seen < n && k < budget) begin
            @(negedge clk);
            k++;
            if (o_cmd_write_stb) seen++;
        end
        chk("stb_timeout", 32'(k < budget), 32'd1);
    endtask

    task automatic frame_req(input logic [15:0] xs, xe, ys, ye);
        @(negedge clk);
        i_x_start = xs;
        i_x_end   = xe;
        i_y_start = ys;
        i_y_end   = ye;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    logic [8:0] exp_frame[11];
    int early;
    int dones;

    initial begin
        exp_frame = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
                      9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
        #3 rst_n = 1'b0;
        i_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_mode", 32'(o_cmd_mode), 32'd1);
        chk("rst_reset_display", 32'(o_reset_display), 32'd1);
        chk("rst_chip_select", 32'(o_chip_select), 32'd0);
        chk("rst_stb", 32'(o_cmd_write_stb), 32'd0);
        chk("rst_param_data", {23'd0, o_cmd_parameter, o_cmd_data}, 32'd0);
        chk("rst_num_pixels", o_num_pixels, 32'd0);
        chk("rst_flags", {28'd0, o_ready, o_busy, o_frame_done, o_error}, 32'd0);

        // power-up
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(2000);
        chk("init_reset_cycles", 32'(rd_cnt), 32'd16);
        chk("init_stb_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("init_slpout", 32'(log_q[0]), 32'h011);
            chk("init_dispon", 32'(log_q[1]), 32'h029);
            chk("init_sleep_gap", 32'((stb_t[1] - stb_t[0]) >= 128), 32'd1);
        end
        chk("init_cs_busy", {30'd0, o_chip_select, o_busy}, 32'b10);

        // full 240x320 frame
        log_q.delete();
        frame_req(16'd0, 16'd239, 16'd0, 16'd319);
        wait_mode0(600);
        chk("frame_stb_count", 32'(log_q.size()), 32'd11);
        for (int i = 0; i < 11 && i < log_q.size(); i++)
            chk($sformatf("frame_byte%0d", i), 32'(log_q[i]), 32'(exp_frame[i]));
        chk("frame_num_pixels", o_num_pixels, 32'd76800);
        chk("frame_busy_ready", {30'd0, o_busy, o_ready}, 32'b10);
        early = 0;
        for (int i = 0; i < 76800; i++) begin
            @(negedge clk);
            if (o_frame_done) early++;
            i_pixel_stb = 1'b1;
            i_start = (i == 100);
        end
        @(negedge clk);
        i_pixel_stb = 1'b0;
        i_start = 1'b0;
        chk("stream_no_early_done", 32'(early), 32'd0);
        chk("stream_done_pulse", 32'(o_frame_done), 32'd1);
        chk("stream_cmd_mode", 32'(o_cmd_mode), 32'd1);
        @(negedge clk);
        chk("stream_done_once", 32'(o_frame_done), 32'd0);
        chk("stream_ready", 32'(o_ready), 32'd1);

        // pixel strobes while idle
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i_pixel_stb = 1'b1;
            if (o_frame_done) dones++;
        end
        @(negedge clk);
        i_pixel_stb = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_pix_no_done", 32'(dones), 32'd0);
        chk("idle_pix_no_stb", 32'(log_q.size()), 32'd11);

        // invalid window, then minimal 1x1 window
        log_q.delete();
        frame_req(16'd10, 16'd5, 16'd0, 16'd0);
        repeat (10) @(negedge clk);
        chk("badwin_error", 32'(o_error), 32'd1);
        chk("badwin_ready", 32'(o_ready), 32'd1);
        chk("badwin_no_stb", 32'(log_q.size()), 32'd0);
        frame_req(16'd0, 16'd0, 16'd0, 16'd0);
        chk("win1_error_clr", 32'(o_error), 32'd0);
        wait_mode0(600);
        chk("win1_num_pixels", o_num_pixels, 32'd1);
        @(negedge clk);
        i_pixel_stb = 1'b1;
        @(negedge clk);
        i_pixel_stb = 1'b0;
        chk("win1_done", 32'(o_frame_done), 32'd1);

        // enable dropped after second CASET parameter
        @(negedge clk);
        log_q.delete();
        frame_req(16'd0, 16'd239, 16'd0, 16'd319);
        wait_stb(3, 200);
        i_enable = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_frame_done) dones++;
        end
        chk("abort_stb_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3)
            chk("abort_last_byte", 32'(log_q[2]), 32'h100);
        chk("abort_mode_ready", {30'd0, o_cmd_mode, o_ready}, 32'b11);
        chk("abort_no_done", 32'(dones), 32'd0);
        i_enable = 1'b1;

        // async reset mid-PASET
        @(negedge clk);
        frame_req(16'd0, 16'd239, 16'd0, 16'd319);
        wait_stb(7, 300);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs",
            {21'd0, o_cmd_mode, o_reset_display, o_chip_select,
             o_cmd_write_stb, o_cmd_parameter, o_ready, o_busy,
             o_frame_done, o_error, 2'b00},
            32'b11000000000);
        chk("midrst_data_num", {24'd0, o_cmd_data} | o_num_pixels, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(2000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
